// File: rtl/cp0_timer_int.sv
// cp0_timer_int: interrupt-source side of CP0.
// Holds Count/Compare, synchronizes the external interrupt lines, merges the
// timer interrupt onto one line and produces the masked interrupt request.

// Single-lane level synchronizer: STAGES flops, no edge detection.
module cp0_int_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw level one stage deeper every edge.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Synchronizer flops; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

module cp0_timer_int #(
   parameter int INT_W       = 6,
   parameter int SYNC_STAGES = 2,
   parameter int COUNT_DIV   = 2,
   parameter int TIMER_BIT   = 5
) (
   input  logic             cpu_clk_50M,
   input  logic             cpu_rst,
   input  logic [INT_W-1:0] ext_int_i,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [31:0]      wdata,
   input  logic             re,
   input  logic [4:0]       raddr,
   input  logic [7:0]       status_im,
   input  logic             status_ie,
   input  logic             status_exl,
   output logic [31:0]      data_o,
   output logic [INT_W-1:0] int_o,
   output logic             int_req_o,
   output logic             timer_pending_o
);

   localparam int              PRE_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(COUNT_DIV - 1);
   localparam logic [4:0]      REG_COUNT   = 5'd9;
   localparam logic [4:0]      REG_COMPARE = 5'd11;

   // Elaboration-time parameter sanity.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("cp0_timer_int: SYNC_STAGES must be at least 2");
   end
   if (COUNT_DIV < 1) begin : g_bad_div
      $error("cp0_timer_int: COUNT_DIV must be at least 1");
   end
   if (TIMER_BIT >= INT_W) begin : g_bad_tbit
      $error("cp0_timer_int: TIMER_BIT must index a valid int_o bit");
   end

   logic [PRE_W-1:0] pre_q,     pre_d;
   logic [31:0]      count_q,   count_d;
   logic [31:0]      compare_q, compare_d;
   logic             pend_q,    pend_d;

   logic             wr_count;
   logic             wr_compare;
   logic [INT_W-1:0] sync_lvl;
   logic [INT_W-1:0] timer_vec;
   logic [INT_W-1:0] int_raw;
   logic [INT_W-1:0] im_hw;
   logic [31:0]      rd_data;
   logic             unused_im;

   assign wr_count   = we && (waddr == REG_COUNT);
   assign wr_compare = we && (waddr == REG_COMPARE);

   // One synchronizer per external interrupt line.
   for (genvar i = 0; i < INT_W; i++) begin : g_sync
      cp0_int_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (cpu_clk_50M),
         .rst (cpu_rst),
         .d   (ext_int_i[i]),
         .q   (sync_lvl[i])
      );
   end

   // Prescaler and Count: a Count write restarts the prescale phase so the
   // first increment after it lands a full COUNT_DIV edges later.
   always_comb begin
      pre_d   = pre_q;
      count_d = count_q;
      if (wr_count) begin
         count_d = wdata;
         pre_d   = '0;
      end else if (pre_q == PRE_LAST) begin
         count_d = count_q + 32'd1;
         pre_d   = '0;
      end else begin
         pre_d   = pre_q + 1'b1;
      end
   end

   // Compare register and sticky timer flag; a Compare write beats a
   // same-cycle match so software can always acknowledge the timer.
   always_comb begin
      compare_d = wr_compare ? wdata : compare_q;
      pend_d    = pend_q;
      if (wr_compare)
         pend_d = 1'b0;
      else if (count_q == compare_q)
         pend_d = 1'b1;
   end

   // Timer state registers.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         pre_q     <= '0;
         count_q   <= '0;
         compare_q <= 32'hFFFF_FFFF;
         pend_q    <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end

   // Interrupt vector: synchronized levels with the timer OR-ed onto its line.
   // Outputs are held quiet while reset is asserted, even before the first edge.
   always_comb begin
      timer_vec = '0;
      timer_vec[TIMER_BIT] = pend_q;
      int_raw   = sync_lvl | timer_vec;
      int_o     = cpu_rst ? '0 : int_raw;
   end

   // Hardware-line mask; software bits IM[1:0] belong to CP0.
   assign im_hw     = INT_W'(status_im[7:2]);
   assign unused_im = ^status_im[1:0];

   // Masked interrupt request.
   always_comb begin
      int_req_o       = (|(int_o & im_hw)) & status_ie & ~status_exl;
      timer_pending_o = pend_q & ~cpu_rst;
   end

   // MFC0 readback of the pre-write register values.
   always_comb begin
      rd_data = '0;
      if (re && (raddr == REG_COUNT))
         rd_data = count_q;
      else if (re && (raddr == REG_COMPARE))
         rd_data = compare_q;
      data_o = cpu_rst ? 32'd0 : rd_data;
   end

endmodule
